bram_image_loader: RTL and testbench

//  Hardware writer for the dual-bank image BRAMs consumed by top_module_imp.
//  On start, it fetches ROWS*COLS pixels per bank from external pixel memory and writes them

---
 rtl/img_pkg.sv | 20 ++
 rtl/colmajor_addr_gen.sv | 59 +++++
 rtl/bram_image_loader.sv | 135 +++++++++++++
 tb/tb_bram_image_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the dual-bank image BRAM loader.
//   DW, AW          pixel width and address width (BRAM port A and external memory)
//   COLS, ROWS      image geometry; COLS is also the BRAM row stride
//   BANK2_OFS       external-memory base of the bank-2 image (bank-1 base is 0)
//   state_t         loader control states
package img_pkg;

    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int COLS      = 4;
    localparam int ROWS      = 12;
    localparam int BANK2_OFS = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/colmajor_addr_gen.sv
// Column-major address generator for the image loader.
// Walks the source image linearly (idx) while row advances fastest and col
// steps each time row wraps, so the BRAM target is col + N_COLS*row.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        reload all counters to 0 (start of a new load)
//   advance      step to the next pixel
//   idx          linear source index (modulo 2^ADDR_W)
//   addr         BRAM target address for the current pixel
//   last         current pixel is row=N_ROWS-1, col=N_COLS-1
module colmajor_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int N_COLS = 4,
    parameter int N_ROWS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // One spare code keeps the widths non-zero for single-row/column images.
    localparam int RW = $clog2(N_ROWS + 1);
    localparam int CW = $clog2(N_COLS + 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic row_last;
    logic col_last;

    assign row_last = (row == RW'(N_ROWS - 1));
    assign col_last = (col == CW'(N_COLS - 1));
    assign last     = row_last && col_last;

    assign addr = ADDR_W'(col) + ADDR_W'(N_COLS) * ADDR_W'(row);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
            if (row_last) begin
                row <= '0;
                col <= col_last ? '0 : col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_image_loader.sv
// Loads two images from external pixel memory into the dual-bank BRAMs of the
// 3x3 window engine. Pixels are read linearly and written column-major,
// both banks in lock-step, then complete is raised.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load (honoured only in IDLE or DONE)
//   ext_ready             external memory accepts a read this cycle
//   ext_rd_en             read strobe to external memory
//   ext_adr1, ext_adr2    bank-1 / bank-2 source addresses
//   ext_data1, ext_data2  read data, valid the cycle after ext_rd_en
//   ena, wea1, wea2       BRAM port-A enable and write enables
//   addra1, addra2        BRAM write addresses (identical)
//   dina1, dina2          BRAM write data
//   complete              load finished, held until the next start
module bram_image_loader
    import img_pkg::*;
#(
    parameter int DW        = img_pkg::DW,
    parameter int AW        = img_pkg::AW,
    parameter int COLS      = img_pkg::COLS,
    parameter int ROWS      = img_pkg::ROWS,
    parameter int BANK2_OFS = img_pkg::BANK2_OFS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ext_ready,
    output logic          ext_rd_en,
    output logic [AW-1:0] ext_adr1,
    output logic [AW-1:0] ext_adr2,
    input  logic [DW-1:0] ext_data1,
    input  logic [DW-1:0] ext_data2,
    output logic          ena,
    output logic          wea1,
    output logic          wea2,
    output logic [AW-1:0] addra1,
    output logic [AW-1:0] addra2,
    output logic [DW-1:0] dina1,
    output logic [DW-1:0] dina2,
    output logic          complete
);

    localparam int N = ROWS * COLS;

    if (N - 1 + BANK2_OFS >= (1 << AW) || N > (1 << AW)) begin : g_width_check
        $error("bram_image_loader: image does not fit in AW-bit address space");
    end

    state_t state;
    state_t state_nxt;

    logic          clear;
    logic          issue;
    logic          issued_all;   // final read of this load has been issued
    logic          pend_valid;   // write stage holds a pixel to store
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] idx;
    logic [AW-1:0] gen_addr;
    logic          gen_last;

    colmajor_addr_gen #(
        .ADDR_W (AW),
        .N_COLS (COLS),
        .N_ROWS (ROWS)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (issue),
        .idx     (idx),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    assign issue = (state == LOAD) && ext_ready && !issued_all;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    clear     = 1'b1;
                end
            end
            LOAD: begin
                // The write now in flight is the last one once all reads are out.
                if (issued_all && pend_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            issued_all <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state      <= state_nxt;
            pend_valid <= issue;
            if (issue) begin
                pend_addr <= gen_addr;
            end
            if (clear) begin
                issued_all <= 1'b0;
            end else if (issue && gen_last) begin
                issued_all <= 1'b1;
            end
        end
    end

    // Address/data buses are forced to 0 outside their strobe cycles so the
    // idle interface is quiet.
    assign ext_rd_en = issue;
    assign ext_adr1  = issue ? idx : '0;
    assign ext_adr2  = issue ? idx + AW'(BANK2_OFS) : '0;

    assign ena    = pend_valid;
    assign wea1   = pend_valid;
    assign wea2   = pend_valid;
    assign addra1 = pend_valid ? pend_addr : '0;
    assign addra2 = pend_valid ? pend_addr : '0;
    assign dina1  = pend_valid ? ext_data1 : '0;
    assign dina2  = pend_valid ? ext_data2 : '0;

    assign complete = (state == DONE);

endmodule

// File: tb/tb_bram_image_loader.sv
module tb_bram_image_loader;
    import img_pkg::*;

    localparam int N    = ROWS * COLS;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ext_ready;
    logic          ext_rd_en;
    logic [AW-1:0] ext_adr1, ext_adr2;
    logic [DW-1:0] ext_data1, ext_data2;
    logic          ena, wea1, wea2;
    logic [AW-1:0] addra1, addra2;
    logic [DW-1:0] dina1, dina2;
    logic          complete;

    always #5 clk = ~clk;

    bram_image_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ext_ready (ext_ready),
        .ext_rd_en (ext_rd_en),
        .ext_adr1  (ext_adr1),
        .ext_adr2  (ext_adr2),
        .ext_data1 (ext_data1),
        .ext_data2 (ext_data2),
        .ena       (ena),
        .wea1      (wea1),
        .wea2      (wea2),
        .addra1    (addra1),
        .addra2    (addra2),
        .dina1     (dina1),
        .dina2     (dina2),
        .complete  (complete)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem   [256];
    logic [DW:0]   bram1 [256];
    logic [DW:0]   bram2 [256];

    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_a1 = '0;
    logic [AW-1:0] prev_a2 = '0;

    // One load scenario: stimulus plus the outcome it must produce.
    // -1 disables a field; exp_done = -2 means "use the reference model".
    typedef struct {
        int stall_lo;
        int stall_hi;
        int extra_start;
        int reset_cyc;
        bit rand_ready;
        bit ident_mem;
        int exp_done;
        int exp_writes;
    } scen_t;

    scen_t scen [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [52:0] pack_outputs();
        return {ext_rd_en, ext_adr1, ext_adr2, ena, wea1, wea2,
                addra1, addra2, dina1, dina2, complete};
    endfunction

    // Drive one cycle's inputs just after the edge, then wait for the
    // falling edge where outputs are sampled. The memory model answers the
    // previous cycle's read.
    task automatic drive_cycle(input logic st, input logic rs, input logic rdy);
        @(posedge clk);
        #1;
        start     = st;
        reset     = rs;
        ext_ready = rdy;
        if (prev_rd) begin
            ext_data1 = mem[prev_a1];
            ext_data2 = mem[prev_a2];
        end else begin
            ext_data1 = DW'($urandom);
            ext_data2 = DW'($urandom);
        end
        @(negedge clk);
        prev_rd = ext_rd_en;
        prev_a1 = ext_adr1;
        prev_a2 = ext_adr2;
        if (wea1) bram1[addra1] = {1'b0, dina1};
        if (wea2) bram2[addra2] = {1'b0, dina2};
    endtask

    task automatic run_scen(input int id, input scen_t s);
        int   rd_k [MAXC];
        bit   rdy  [MAXC];
        int   issued   = 0;
        int   last_rd  = -1;
        int   done_cyc;
        int   end_c;
        int   obs_done = -1;
        int   writes   = 0;
        int   kw;
        int   want_done;
        bit   in_rst, e_rd, e_wr, e_cmp;
        logic [AW-1:0] e_a1, e_a2, e_wa;
        logic [DW-1:0] e_d1, e_d2;

        for (int i = 0; i < 256; i++) begin
            mem[i]   = s.ident_mem ? DW'(i) : DW'($urandom);
            bram1[i] = {1'b1, {DW{1'b0}}};
            bram2[i] = {1'b1, {DW{1'b0}}};
        end

        // Reference: the k-th read lands on the k-th LOAD cycle with ready
        // high, its write one cycle later, complete two cycles after the last read.
        for (int c = 0; c < MAXC; c++) begin
            rdy[c]  = s.rand_ready ? ($urandom_range(0, 3) != 0)
                                   : !(c >= s.stall_lo && c <= s.stall_hi);
            rd_k[c] = -1;
            if (issued < N && rdy[c] && (s.reset_cyc < 0 || c < s.reset_cyc)) begin
                rd_k[c] = issued;
                issued++;
                last_rd = c;
            end
        end
        done_cyc = (issued == N) ? last_rd + 2 : -1;
        if (s.reset_cyc >= 0)   end_c = s.reset_cyc + 2;
        else if (done_cyc >= 0) end_c = done_cyc + 2;
        else                    end_c = MAXC - 1;

        drive_cycle(1'b1, 1'b0, 1'($urandom));

        for (int c = 0; c <= end_c; c++) begin
            drive_cycle(1'(c == s.extra_start),
                        1'(s.reset_cyc > 0 && c == s.reset_cyc - 1),
                        rdy[c]);
            in_rst = (s.reset_cyc >= 0 && c >= s.reset_cyc);
            e_rd   = !in_rst && rd_k[c] >= 0;
            e_wr   = !in_rst && c > 0 && rd_k[c-1] >= 0;
            e_cmp  = done_cyc >= 0 && c >= done_cyc;
            kw     = (c > 0) ? rd_k[c-1] : 0;
            e_a1   = e_rd ? AW'(rd_k[c]) : '0;
            e_a2   = e_rd ? AW'(rd_k[c] + BANK2_OFS) : '0;
            e_wa   = e_wr ? AW'(kw / ROWS + COLS * (kw % ROWS)) : '0;
            e_d1   = e_wr ? mem[kw] : '0;
            e_d2   = e_wr ? mem[kw + BANK2_OFS] : '0;
            check($sformatf("scen%0d cycle%0d outputs", id, c),
                  64'(pack_outputs()),
                  64'({e_rd, e_a1, e_a2, e_wr, e_wr, e_wr, e_wa, e_wa, e_d1, e_d2, e_cmp}));
            if (complete && obs_done < 0) obs_done = c;
            if (wea1) writes++;
        end

        want_done = (s.exp_done == -2) ? done_cyc : s.exp_done;
        check($sformatf("scen%0d complete_cycle", id), 64'(obs_done), 64'(want_done));
        check($sformatf("scen%0d write_count", id), 64'(writes), 64'(s.exp_writes));

        if (s.reset_cyc < 0) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = k / ROWS + COLS * (k % ROWS);
                check($sformatf("scen%0d bram_pixel%0d", id, k),
                      64'({bram1[a], bram2[a]}),
                      64'({1'b0, mem[k], 1'b0, mem[k + BANK2_OFS]}));
            end
        end
    endtask

    initial begin
        //            lo  hi  st  rst rand ident done wr
        scen[0] = '{-1, -1, -1, -1, 1'b0, 1'b1, 49, 48};  // basic full-rate load
        scen[1] = '{ 5,  9, -1, -1, 1'b0, 1'b0, 54, 48};  // ready stall, restart from DONE
        scen[2] = '{-1, -1, 20, -1, 1'b0, 1'b0, 49, 48};  // start mid-LOAD ignored
        scen[3] = '{-1, -1, -1, -1, 1'b0, 1'b0, 49, 48};  // restart from DONE
        scen[4] = '{-1, -1, -1, 30, 1'b0, 1'b0, -1, 29};  // reset mid-LOAD
        scen[5] = '{-1, -1, -1, -1, 1'b0, 1'b1, 49, 48};  // fresh load after reset
        scen[6] = '{-1, -1, -1, -1, 1'b1, 1'b0, -2, 48};  // random ready
        scen[7] = '{-1, -1, -1, -1, 1'b1, 1'b0, -2, 48};  // random ready

        reset     = 1'b1;
        start     = 1'b0;
        ext_ready = 1'b0;
        ext_data1 = '0;
        ext_data2 = '0;

        // Reset state: everything low, even with start and ready high.
        drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1);
        check("reset_outputs", 64'(pack_outputs()), 64'(0));

        // IDLE ignores ext_ready without start.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            check($sformatf("idle_quiet%0d", i), 64'(pack_outputs()), 64'(0));
        end

        for (int i = 0; i < 8; i++) begin
            run_scen(i, scen[i]);
        end

        // DONE holds complete with a quiet interface while start stays low.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            check($sformatf("done_hold%0d", i), 64'(pack_outputs()), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
